mod_reduce_iter: RTL and testbench
==================================

// Module: mod_reduce_iter
// PURPOSE
//   Parametrised iterative modular reducer: result = in_a mod in_n, in_a up to AW bits, in_n W bits.
//   Restoring shift/conditional-subtract datapath, K dividend bits consumed per clock.
//   Serves RSA datapath pre-/post-reduction (e.g. 2W-bit products, operands >= N) ahead of Montgomery.
// PARAMETERS
//   W    512   modulus/result width in bits
//   AW   1024  dividend width in bits; AW >= W, AW % K == 0
//   K    1     bits retired per cycle (1, 2 or 4); K chained subtract stages per cycle
// PORTS
//   clk       in   1   rising-edge clock
//   resetn    in   1   asynchronous active-low reset
//   start     in   1   1-cycle request; in_a/in_n sampled on the same edge
//   in_a      in   AW  dividend, unsigned
//   in_n      in   W   modulus, unsigned, nonzero
//   result    out  W   remainder; valid from done, held until next accepted start
//   done      out  1   1-cycle completion pulse
//   busy      out  1   high from the cycle after start is accepted through the done cycle
//   err       out  1   set with done when in_n == 0; cleared at next accepted start
//   quotient  out  AW  floor(in_a/in_n); present only when MOD_QUOTIENT_EN is defined
// BEHAVIOUR
//   Reset (async, resetn=0): state=IDLE; result=0, done=0, busy=0, err=0, quotient=0, counter=0.
//   FSM: IDLE -> RUN -> DONE -> IDLE.
//     IDLE: start=1 -> latch a_reg=in_a, n_reg=in_n, r=0 (W+1 bits), cnt=AW/K-1.
//           If in_n==0 -> DONE with err=1, result=0 (latency 1); else -> RUN.
//     RUN : per step i (K per cycle, MSB first): r=(r<<1)|a_reg[MSB]; a_reg<<=1;
//           if r >= n_reg then r -= n_reg (and quotient bit=1). Invariant r < n_reg.
//           cnt==0 at end of cycle -> DONE; else cnt--.
//     DONE: done=1 for exactly one cycle, result=r[W-1:0]; busy=1 in this cycle.
//           start=1 in DONE is accepted (same as IDLE) -> back-to-back ops, no idle gap.
//   Latency: done high AW/K+1 rising edges after start edge (nonzero n). W=512,AW=1024,K=1: 1025.
//   start while RUN: ignored, no effect on operands or counter.
//   in_a, in_n may change freely after the start edge.
//   Width rules: r held W+1 bits so (r<<1)|b < 2*n_reg never overflows; compare/sub W+1 bits.
//   in_a < in_n -> result = in_a[W-1:0]; in_a == in_n -> 0; in_n==1 -> 0.
//   resetn deasserted mid-RUN: operation abandoned, outputs to reset values, no done pulse.
// CONFIGURATION
//   MOD_QUOTIENT_EN defined: quotient port exists; q shift register (AW bits) fills one bit per step,
//     updated with result at DONE, held until next accepted start; err case -> quotient=0.
//   Not defined: no quotient port, no q register; remainder behaviour and latency identical.
// STRUCTURE
//   mod_pkg: state encoding (ST_IDLE, ST_RUN, ST_DONE), localparam NSTEP=AW/K, CNT_W=$clog2(NSTEP).
//   Sub-module mod_csub_stage (combinational): in r(W+1), bit b, n(W) -> out r', qbit;
//     instantiated K times in a generate chain; top holds FSM, counter and registers.
//   Parameter legality (AW%K, AW>=W, K in {1,2,4}) checked by elaboration-time $error.
// TESTING
//   W=8,AW=16,K=1: in_a=16'h1234, in_n=8'h37 -> result=8'h28, done at edge 17, err=0 (quotient=16'h0054).
//   W=8,AW=16,K=4: same vector -> result=8'h28 at edge 5; in_a=16'h00FF,n=8'hFF -> 0; in_a=5,n=FF -> 5.
//   in_n=0, in_a=16'hBEEF -> done at edge 1, err=1, result=0; next valid start clears err.
//   Defaults: in_a={512'h0, 512'hf59b..0765}, in_n=512'h9b52..c663 -> result=512'h5a49..4102 at edge 1025.
//   Pulse start at cycle 5 of RUN -> ignored, result unchanged; start in DONE cycle -> second op runs back-to-back.
//   resetn low at RUN cycle 7 -> busy/done/result=0 immediately; fresh start afterwards gives correct result.

Source files
------------

// File: rtl/mod_pkg.sv
// rtl/mod_pkg.sv - shared state encoding and sizing helpers for the iterative modular reducer
package mod_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_W  = 512;
    localparam int DEF_AW = 1024;
    localparam int DEF_K  = 1;

    function automatic int nstep(input int aw, input int k);
        return aw / k;
    endfunction

    // Counter needs at least one bit even when a single cycle covers the whole dividend.
    function automatic int cnt_width(input int steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

endpackage

// File: rtl/mod_csub_stage.sv
// rtl/mod_csub_stage.sv - one restoring step: shift in a dividend bit, subtract modulus if it fits
module mod_csub_stage #(
    parameter int W = 8
) (
    input  logic [W:0]   r_in,
    input  logic         b,
    input  logic [W-1:0] n,
    output logic [W:0]   r_out,
    output logic         qbit
);

    logic [W:0] t;
    logic       unused_msb;

    // r_in < n always holds, so its top bit is zero and the shift cannot overflow W+1 bits.
    assign unused_msb = r_in[W];
    assign t          = {r_in[W-1:0], b};
    assign qbit       = (t >= {1'b0, n});
    assign r_out      = qbit ? (t - {1'b0, n}) : t;

endmodule

// File: rtl/mod_reduce_iter.sv
// rtl/mod_reduce_iter.sv - iterative result = in_a mod in_n, K bits per clock; MOD_QUOTIENT_EN adds quotient port
module mod_reduce_iter
    import mod_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int AW = DEF_AW,
    parameter int K  = DEF_K
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic [AW-1:0] in_a,
    input  logic [W-1:0]  in_n,
    output logic [W-1:0]  result,
    output logic          done,
    output logic          busy,
`ifdef MOD_QUOTIENT_EN
    output logic [AW-1:0] quotient,
`endif
    output logic          err
);

    localparam int NSTEP = nstep(AW, K);
    localparam int CNT_W = cnt_width(NSTEP);

    if ((AW % K) != 0 || AW < W || !(K == 1 || K == 2 || K == 4)) begin : g_bad_params
        $error("mod_reduce_iter: illegal parameters W=%0d AW=%0d K=%0d", W, AW, K);
    end

    state_t         state;
    logic [W:0]     r;
    logic [AW-1:0]  a_reg;
    logic [W-1:0]   n_reg;
    logic [CNT_W-1:0] cnt;

    logic [W:0]     r_chain [0:K];
    logic [K-1:0]   qbits;

    assign r_chain[0] = r;

    for (genvar k = 0; k < K; k++) begin : g_stage
        mod_csub_stage #(.W(W)) u_stage (
            .r_in  (r_chain[k]),
            .b     (a_reg[AW-1-k]),
            .n     (n_reg),
            .r_out (r_chain[k+1]),
            .qbit  (qbits[K-1-k])
        );
    end

`ifdef MOD_QUOTIENT_EN
    logic [AW-1:0]   q_reg;
    logic [AW+K-1:0] q_cat;
    logic [AW-1:0]   q_next;
    assign q_cat  = {q_reg, qbits};
    assign q_next = q_cat[AW-1:0];
`else
    logic unused_qbits;
    assign unused_qbits = ^qbits;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= ST_IDLE;
            result <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
            err    <= 1'b0;
            cnt    <= '0;
            r      <= '0;
            a_reg  <= '0;
            n_reg  <= '0;
`ifdef MOD_QUOTIENT_EN
            q_reg    <= '0;
            quotient <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                // DONE accepts a new start exactly like IDLE so operations can run back-to-back.
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        a_reg <= in_a;
                        n_reg <= in_n;
                        r     <= '0;
                        cnt   <= CNT_W'(NSTEP - 1);
                        err   <= 1'b0;
                        busy  <= 1'b1;
`ifdef MOD_QUOTIENT_EN
                        q_reg <= '0;
`endif
                        if (in_n == '0) begin
                            state  <= ST_DONE;
                            done   <= 1'b1;
                            err    <= 1'b1;
                            result <= '0;
`ifdef MOD_QUOTIENT_EN
                            quotient <= '0;
`endif
                        end else begin
                            state <= ST_RUN;
                        end
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r     <= r_chain[K];
                    a_reg <= a_reg << K;
`ifdef MOD_QUOTIENT_EN
                    q_reg <= q_next;
`endif
                    if (cnt == '0) begin
                        state  <= ST_DONE;
                        done   <= 1'b1;
                        result <= r_chain[K][W-1:0];
`ifdef MOD_QUOTIENT_EN
                        quotient <= q_next;
`endif
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod_reduce_iter.sv
// tb/tb_mod_reduce_iter.sv - directed bench for mod_reduce_iter at W=8, AW=16 with K=1 and K=4
module tb_mod_reduce_iter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [15:0] in_a;
    logic [7:0]  in_n;
    logic [7:0]  result1, result4;
    logic        done1, done4, busy1, busy4, err1, err4;
`ifdef MOD_QUOTIENT_EN
    logic [15:0] quot1, quot4;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mod_reduce_iter #(.W(8), .AW(16), .K(1)) u_k1 (
        .clk(clk), .resetn(resetn), .start(start), .in_a(in_a), .in_n(in_n),
        .result(result1), .done(done1), .busy(busy1),
`ifdef MOD_QUOTIENT_EN
        .quotient(quot1),
`endif
        .err(err1)
    );

    mod_reduce_iter #(.W(8), .AW(16), .K(4)) u_k4 (
        .clk(clk), .resetn(resetn), .start(start), .in_a(in_a), .in_n(in_n),
        .result(result4), .done(done4), .busy(busy4),
`ifdef MOD_QUOTIENT_EN
        .quotient(quot4),
`endif
        .err(err4)
    );

    typedef struct {
        logic [15:0] a;
        logic [7:0]  n;
        logic [7:0]  r;
        logic        e;
        logic [15:0] q;
    } vec_t;

    vec_t vecs [12];

    logic        seen1, seen4, e1, e4, busy1_t0;
    int          lat1, lat4;
    logic [7:0]  res1, res4;
    logic [15:0] qq1, qq4;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic sample(input int t);
        if (t == 0) busy1_t0 = busy1;
        if (!seen1 && done1) begin
            seen1 = 1'b1; lat1 = t; res1 = result1; e1 = err1;
`ifdef MOD_QUOTIENT_EN
            qq1 = quot1;
`endif
        end
        if (!seen4 && done4) begin
            seen4 = 1'b1; lat4 = t; res4 = result4; e4 = err4;
`ifdef MOD_QUOTIENT_EN
            qq4 = quot4;
`endif
        end
    endtask

    // Called #1 after a rising edge; t counts edges after the start edge.
    task automatic run_op(input logic [15:0] a, input logic [7:0] n,
                          input int pulse_at, input logic [15:0] a2, input logic [7:0] n2);
        int t;
        seen1 = 1'b0; seen4 = 1'b0; lat1 = -1; lat4 = -1;
        res1 = 'x; res4 = 'x; e1 = 'x; e4 = 'x; qq1 = 'x; qq4 = 'x;
        in_a = a; in_n = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; in_a = 16'hDEAD; in_n = 8'h5A;
        t = 0;
        sample(t);
        while (!(seen1 && seen4) && t < 40) begin
            if (t + 1 == pulse_at) begin
                start = 1'b1; in_a = a2; in_n = n2;
            end
            @(posedge clk); #1;
            start = 1'b0;
            t++;
            sample(t);
        end
    endtask

    task automatic check_op(input string tag, input logic [7:0] r, input logic e, input logic [15:0] q);
        check({tag, " k1 result"}, {24'h0, res1}, {24'h0, r});
        check({tag, " k4 result"}, {24'h0, res4}, {24'h0, r});
        check({tag, " k1 err"}, {31'h0, e1}, {31'h0, e});
        check({tag, " k4 err"}, {31'h0, e4}, {31'h0, e});
        check({tag, " k1 latency"}, lat1, e ? 32'd0 : 32'd16);
        check({tag, " k4 latency"}, lat4, e ? 32'd0 : 32'd4);
`ifdef MOD_QUOTIENT_EN
        check({tag, " k1 quotient"}, {16'h0, qq1}, {16'h0, q});
        check({tag, " k4 quotient"}, {16'h0, qq4}, {16'h0, q});
`else
        if (q === 16'hxxxx) $display("unexpected quotient vector");
`endif
    endtask

    initial begin
        vecs[0]  = '{16'h1234, 8'h37, 8'h28, 1'b0, 16'h0054};
        vecs[1]  = '{16'h00FF, 8'hFF, 8'h00, 1'b0, 16'h0001};
        vecs[2]  = '{16'h0005, 8'hFF, 8'h05, 1'b0, 16'h0000};
        vecs[3]  = '{16'hFFFF, 8'h01, 8'h00, 1'b0, 16'hFFFF};
        vecs[4]  = '{16'hFFFF, 8'hFF, 8'h00, 1'b0, 16'h0101};
        vecs[5]  = '{16'hFFFF, 8'hFE, 8'h03, 1'b0, 16'h0102};
        vecs[6]  = '{16'h00FE, 8'hFF, 8'hFE, 1'b0, 16'h0000};
        vecs[7]  = '{16'h1000, 8'h07, 8'h01, 1'b0, 16'h0249};
        vecs[8]  = '{16'hABCD, 8'h80, 8'h4D, 1'b0, 16'h0157};
        vecs[9]  = '{16'hBEEF, 8'h00, 8'h00, 1'b1, 16'h0000};
        vecs[10] = '{16'h0064, 8'h0A, 8'h00, 1'b0, 16'h000A};
        vecs[11] = '{16'h7FFF, 8'hC8, 8'hA7, 1'b0, 16'h00A3};

        resetn = 1'b0; start = 1'b0; in_a = '0; in_n = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset result", {16'h0, result1, result4}, 32'h0);
        check("reset done/busy/err", {26'h0, done1, done4, busy1, busy4, err1, err4}, 32'h0);
        @(negedge clk); resetn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].a, vecs[i].n, -1, '0, '0);
            check_op($sformatf("vec%0d", i), vecs[i].r, vecs[i].e, vecs[i].q);
            @(posedge clk); #1;
            check($sformatf("vec%0d idle after done", i), {30'h0, busy1, done1}, 32'h0);
        end

        // Start pulse while both instances are mid-RUN must be ignored.
        run_op(16'h1234, 8'h37, 3, 16'hFFFF, 8'h01);
        check_op("ignored start", 8'h28, 1'b0, 16'h0054);
        @(posedge clk); #1;

        // Back-to-back: second start lands in the K=1 DONE cycle.
        run_op(16'hFFFF, 8'hFE, -1, '0, '0);
        check_op("b2b first", 8'h03, 1'b0, 16'h0102);
        run_op(16'h1234, 8'h37, -1, '0, '0);
        check_op("b2b second", 8'h28, 1'b0, 16'h0054);
        check("b2b busy held", {31'h0, busy1_t0}, 32'h1);

        // Error clears on the next valid start.
        run_op(16'hBEEF, 8'h00, -1, '0, '0);
        check_op("err", 8'h00, 1'b1, 16'h0000);
        @(posedge clk); #1;
        run_op(16'h00FE, 8'hFF, -1, '0, '0);
        check_op("err cleared", 8'hFE, 1'b0, 16'h0000);
        @(posedge clk); #1;

        // Asynchronous reset mid-RUN abandons the op.
        in_a = 16'h1234; in_n = 8'h37; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("pre-reset busy", {31'h0, busy1}, 32'h1);
        resetn = 1'b0;
        #1;
        check("midrun reset result", {16'h0, result1, result4}, 32'h0);
        check("midrun reset flags", {26'h0, done1, done4, busy1, busy4, err1, err4}, 32'h0);
        repeat (20) begin
            @(posedge clk); #1;
            if (done1 || done4) check("no done during reset", {30'h0, done1, done4}, 32'h0);
        end
        @(negedge clk); resetn = 1'b1;
        @(posedge clk); #1;
        run_op(16'hFFFF, 8'hFE, -1, '0, '0);
        check_op("after reset", 8'h03, 1'b0, 16'h0102);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
